tl_burst_arbiter: RTL and testbench
===================================

TL_BURST_ARBITER -- requirements
Module: tl_burst_arbiter

Interface
REQ-001 SHALL have parameter N_MASTER, default 4: number of requesting masters, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 64: width of each master's payload bits.
REQ-003 SHALL have parameter SIZE_W, default 3: width of the TileLink size field (log2 bytes).
REQ-004 SHALL have parameter BEAT_BYTES, default 8: bytes per beat, a power of two; LOG_BEAT = log2(BEAT_BYTES).
REQ-005 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-006 SHALL have port clk_i, input, 1: single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port inp_bits_i, input, N_MASTER*DATA_W: per-master payload, master k at slice k.
REQ-009 SHALL have port inp_size_i, input, N_MASTER*SIZE_W: per-master size field.
REQ-010 SHALL have port inp_has_data_i, input, N_MASTER: per-master flag, 1 = message carries data beats.
REQ-011 SHALL have port inp_valid_i, input, N_MASTER: per-master valid.
REQ-012 SHALL have port inp_ready_o, output, N_MASTER: per-master ready.
REQ-013 SHALL have port oup_valid_o, output, 1: arbitrated valid.
REQ-014 SHALL have port oup_bits_o, output, DATA_W: payload of the granted master.
REQ-015 SHALL have port oup_size_o, output, SIZE_W: size field of the granted master.
REQ-016 SHALL have port oup_idx_o, output, clog2(N_MASTER): index of the granted master.
REQ-017 SHALL have port oup_ready_i, input, 1: downstream ready.
REQ-018 SHALL have port locked_o, output, 1: high while in BURST state.

Function
REQ-019 SHALL compute beats = 2^(size-LOG_BEAT) when has_data=1 and size>LOG_BEAT, else 1; the beat counter SHALL be wide enough for the maximum beats with no truncation.
REQ-020 SHALL implement a two-state FSM: IDLE (arbitrating) and BURST (locked to lock_idx).
REQ-021 IDLE: eligible set = inp_valid_i; winner per ARB_MODE; round-robin searches upward from rr_ptr with wrap-around N_MASTER-1 -> 0.
REQ-022 SHALL drive oup_valid_o = inp_valid_i[g], oup_bits_o/oup_size_o/oup_idx_o from g, inp_ready_o[g] = oup_ready_i, and all other inp_ready_o bits 0, where g is the current grant.
REQ-023 IDLE: if oup_valid_o=1 and oup_ready_i=0, SHALL register g as hold_idx and keep the same grant every following cycle until the handshake, even if a higher-priority master asserts valid.
REQ-024 SHALL count a handshake as oup_valid_o & oup_ready_i; at most one beat per cycle.
REQ-025 On an IDLE handshake with beats=1, SHALL remain in IDLE and clear the hold.
REQ-026 On an IDLE handshake with beats>1, SHALL go to BURST with lock_idx=g and counter=beats-1.
REQ-027 BURST: only lock_idx is eligible; oup_valid_o = inp_valid_i[lock_idx]; other masters' ready = 0 regardless of their valid.
REQ-028 BURST: each handshake SHALL decrement the counter; a handshake with counter==1 SHALL return to IDLE in the next cycle; size/has_data of beats after the first SHALL be ignored.
REQ-029 In round-robin mode, SHALL update rr_ptr to (g+1) mod N_MASTER on every first-beat handshake; in fixed mode rr_ptr is unused.
REQ-030 SHALL be combinational valid->valid and ready->ready (zero-cycle latency); there SHALL be no combinational path from oup_ready_i to oup_valid_o.
REQ-031 With no input valid, SHALL drive oup_valid_o=0, oup_bits_o=0, oup_size_o=0 and oup_idx_o=0.
REQ-032 A lock master dropping valid mid-burst SHALL stall the burst (counter held, lock kept); no other master may be granted.

Reset
REQ-033 While rst_i=0, SHALL asynchronously force state=IDLE, counter=0, lock_idx=0, rr_ptr=0 and hold cleared; outputs SHALL then follow REQ-031/REQ-022 combinationally, with locked_o=0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst; after release the FSM SHALL arbitrate freshly from rr_ptr=0.

Verification
REQ-035 Single beat, round-robin: masters 0..3 all valid with has_data=0, oup_ready_i=1 for 4 cycles -> oup_idx_o sequence 0,1,2,3 and locked_o=0 throughout.
REQ-036 Burst lock: master 2 sends size=5, has_data=1 (4 beats) while masters 0 and 1 stay valid -> 4 consecutive handshakes with oup_idx_o=2, locked_o=1 for beats 2-4, then master 3 is granted next.
REQ-037 Backpressure hold: master 3 valid and oup_ready_i=0 for 3 cycles, then master 0 raises valid -> oup_idx_o stays 3 until the handshake.
REQ-038 Stall mid-burst: master 1 sends an 8-beat burst (size=6) and drops valid after beat 3 for 5 cycles while others are valid -> oup_valid_o=0 for those cycles, then beats 4-8 come from master 1.
REQ-039 Fixed priority (ARB_MODE=0): masters 1 and 3 continuously valid with single beats -> master 1 always granted and master 3 never granted.
REQ-040 Reset mid-burst: rst_i=0 during beat 2 of 4 -> locked_o=0 immediately; after release with masters 1 and 2 valid, master 1 is granted (rr_ptr=0).

Source files
------------

// File: rtl/tl_burst_arbiter.sv
// tl_burst_arbiter: TileLink N-master arbiter (fixed or round-robin) that holds its grant under backpressure and locks to one master for multi-beat bursts.
//   clk_i, rst_i (async, active-low)
//   inp_bits_i/inp_size_i/inp_has_data_i/inp_valid_i -> per-master requests, inp_ready_o per-master ready
//   oup_valid_o/oup_bits_o/oup_size_o/oup_idx_o -> granted request, oup_ready_i downstream ready
//   locked_o -> high while a multi-beat burst owns the output
module tl_burst_arbiter #(
  parameter int N_MASTER   = 4,
  parameter int DATA_W     = 64,
  parameter int SIZE_W     = 3,
  parameter int BEAT_BYTES = 8,
  parameter int ARB_MODE   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_MASTER*DATA_W-1:0]   inp_bits_i,
  input  logic [N_MASTER*SIZE_W-1:0]   inp_size_i,
  input  logic [N_MASTER-1:0]          inp_has_data_i,
  input  logic [N_MASTER-1:0]          inp_valid_i,
  output logic [N_MASTER-1:0]          inp_ready_o,
  output logic                         oup_valid_o,
  output logic [DATA_W-1:0]            oup_bits_o,
  output logic [SIZE_W-1:0]            oup_size_o,
  output logic [$clog2(N_MASTER)-1:0]  oup_idx_o,
  input  logic                         oup_ready_i,
  output logic                         locked_o
);
  localparam int LOG_BEAT = $clog2(BEAT_BYTES);
  localparam int IDX_W    = $clog2(N_MASTER);
  localparam int MAX_SIZE = (1 << SIZE_W) - 1;
  localparam int CNT_W    = (MAX_SIZE > LOG_BEAT ? MAX_SIZE - LOG_BEAT : 0) + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t           state;
  logic [IDX_W-1:0] lock_idx, hold_idx, rr_ptr, arb_idx, g;
  logic             hold_vld, found, any_v, g_hd, hs;
  logic [CNT_W-1:0] cnt, beats;
  logic [SIZE_W-1:0] g_size;
  always_comb begin
    int j;
    arb_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N_MASTER; i++) begin
      j = (ARB_MODE != 0) ? (int'(rr_ptr) + i) % N_MASTER : i;
      if (!found && inp_valid_i[j]) begin
        arb_idx = IDX_W'(j);
        found   = 1'b1;
      end
    end
  end
  // a burst lock outranks a backpressure hold, which outranks fresh arbitration
  assign g           = state == BURST ? lock_idx : hold_vld ? hold_idx : arb_idx;
  assign any_v       = |inp_valid_i;
  assign oup_valid_o = inp_valid_i[g];
  assign oup_bits_o  = any_v ? inp_bits_i[int'(g)*DATA_W +: DATA_W] : '0;
  assign oup_size_o  = any_v ? g_size : '0;
  assign oup_idx_o   = any_v ? g : '0;
  assign g_size      = inp_size_i[int'(g)*SIZE_W +: SIZE_W];
  assign g_hd        = inp_has_data_i[g];
  assign inp_ready_o = oup_ready_i ? N_MASTER'(1) << g : '0;
  assign hs          = oup_valid_o & oup_ready_i;
  assign locked_o    = state == BURST;
  assign beats       = (g_hd && g_size > SIZE_W'(LOG_BEAT)) ? CNT_W'(1) << (g_size - SIZE_W'(LOG_BEAT)) : CNT_W'(1);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      lock_idx <= '0;
      hold_idx <= '0;
      hold_vld <= 1'b0;
      rr_ptr   <= '0;
    end else if (state == IDLE) begin
      if (hs) begin
        hold_vld <= 1'b0;
        if (ARB_MODE != 0) rr_ptr <= g == IDX_W'(N_MASTER - 1) ? '0 : g + 1'b1;
        if (beats != CNT_W'(1)) begin
          state    <= BURST;
          lock_idx <= g;
          cnt      <= beats - 1'b1;
        end
      end else if (oup_valid_o) begin
        hold_vld <= 1'b1;
        hold_idx <= g;
      end
    end else if (hs) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_tl_burst_arbiter.sv
// tb_tl_burst_arbiter: directed checks of round-robin and fixed-priority arbitration, burst lock, hold and reset.
module tb_tl_burst_arbiter;
  localparam int N = 4, DW = 64, SW = 3;
  logic clk_i = 1'b0, rst_i = 1'b0, oup_ready_i;
  logic [N*DW-1:0] inp_bits_i;
  logic [N*SW-1:0] inp_size_i;
  logic [N-1:0] inp_has_data_i, inp_valid_i, inp_ready_o, fp_ready;
  logic oup_valid_o, fp_valid, locked_o, fp_locked;
  logic [DW-1:0] oup_bits_o, fp_bits;
  logic [SW-1:0] oup_size_o, fp_size;
  logic [1:0] oup_idx_o, fp_idx;
  int checks = 0, failures = 0;
  tl_burst_arbiter #(.N_MASTER(N), .DATA_W(DW), .SIZE_W(SW), .BEAT_BYTES(8), .ARB_MODE(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inp_bits_i(inp_bits_i), .inp_size_i(inp_size_i),
    .inp_has_data_i(inp_has_data_i), .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o),
    .oup_valid_o(oup_valid_o), .oup_bits_o(oup_bits_o), .oup_size_o(oup_size_o),
    .oup_idx_o(oup_idx_o), .oup_ready_i(oup_ready_i), .locked_o(locked_o));
  tl_burst_arbiter #(.N_MASTER(N), .DATA_W(DW), .SIZE_W(SW), .BEAT_BYTES(8), .ARB_MODE(0)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i), .inp_bits_i(inp_bits_i), .inp_size_i(inp_size_i),
    .inp_has_data_i(inp_has_data_i), .inp_valid_i(inp_valid_i), .inp_ready_o(fp_ready),
    .oup_valid_o(fp_valid), .oup_bits_o(fp_bits), .oup_size_o(fp_size),
    .oup_idx_o(fp_idx), .oup_ready_i(oup_ready_i), .locked_o(fp_locked));
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic set_m(input int k, input int sz, input bit hd);
    inp_size_i[k*SW +: SW] = SW'(sz);
    inp_has_data_i[k] = hd;
  endtask
  initial begin
    for (int k = 0; k < N; k++) inp_bits_i[k*DW +: DW] = 64'hA0 + 64'(k);
    inp_size_i = '0;
    inp_has_data_i = '0;
    inp_valid_i = '0;
    oup_ready_i = 1'b0;
    repeat (2) tick;
    check("rst_valid", 64'(oup_valid_o), 0);
    check("rst_bits", oup_bits_o, 0);
    check("rst_size", 64'(oup_size_o), 0);
    check("rst_idx", 64'(oup_idx_o), 0);
    check("rst_locked", 64'(locked_o), 0);
    rst_i = 1'b1;
    inp_valid_i = 4'hF;
    oup_ready_i = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      check("rr_idx", 64'(oup_idx_o), 64'(c));
      check("rr_bits", oup_bits_o, 64'hA0 + 64'(c));
      check("rr_ready", 64'(inp_ready_o), 64'(1) << c);
      check("rr_locked", 64'(locked_o), 0);
      tick;
    end
    inp_valid_i = 4'b0010;
    #1;
    check("pre_burst_idx", 64'(oup_idx_o), 1);
    tick;
    set_m(2, 5, 1);
    inp_valid_i = 4'hF;
    #1;
    check("burst_b1_idx", 64'(oup_idx_o), 2);
    check("burst_b1_size", 64'(oup_size_o), 5);
    check("burst_b1_locked", 64'(locked_o), 0);
    tick;
    for (int b = 2; b <= 4; b++) begin
      check("burst_idx", 64'(oup_idx_o), 2);
      check("burst_locked", 64'(locked_o), 1);
      check("burst_ready", 64'(inp_ready_o), 64'b0100);
      tick;
    end
    set_m(2, 0, 0);
    #1;
    check("post_burst_idx", 64'(oup_idx_o), 3);
    check("post_burst_locked", 64'(locked_o), 0);
    tick;
    inp_valid_i = 4'b1000;
    oup_ready_i = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("bp_idx", 64'(oup_idx_o), 3);
      check("bp_valid", 64'(oup_valid_o), 1);
      check("bp_ready", 64'(inp_ready_o), 0);
      tick;
    end
    inp_valid_i = 4'b1001;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("hold_idx", 64'(oup_idx_o), 3);
      tick;
    end
    oup_ready_i = 1'b1;
    #1;
    check("hold_hs_idx", 64'(oup_idx_o), 3);
    check("hold_hs_ready", 64'(inp_ready_o), 64'b1000);
    tick;
    check("after_hold_idx", 64'(oup_idx_o), 0);
    tick;
    set_m(1, 6, 1);
    inp_valid_i = 4'hF;
    #1;
    check("stall_b1_idx", 64'(oup_idx_o), 1);
    check("stall_b1_locked", 64'(locked_o), 0);
    tick;
    for (int b = 2; b <= 3; b++) begin
      check("stall_pre_idx", 64'(oup_idx_o), 1);
      check("stall_pre_locked", 64'(locked_o), 1);
      tick;
    end
    inp_valid_i = 4'b1101;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 64'(oup_valid_o), 0);
      check("stall_locked", 64'(locked_o), 1);
      check("stall_ready", 64'(inp_ready_o), 64'b0010);
      tick;
    end
    inp_valid_i = 4'hF;
    #1;
    for (int b = 4; b <= 8; b++) begin
      check("resume_idx", 64'(oup_idx_o), 1);
      check("resume_valid", 64'(oup_valid_o), 1);
      check("resume_locked", 64'(locked_o), 1);
      tick;
    end
    set_m(1, 0, 0);
    #1;
    check("after_stall_idx", 64'(oup_idx_o), 2);
    check("after_stall_locked", 64'(locked_o), 0);
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    inp_valid_i = 4'b1010;
    #1;
    for (int c = 0; c < 4; c++) begin
      check("fp_idx", 64'(fp_idx), 1);
      check("fp_ready", 64'(fp_ready), 64'b0010);
      check("rr_alt_idx", 64'(oup_idx_o), (c % 2) ? 3 : 1);
      tick;
    end
    set_m(2, 5, 1);
    inp_valid_i = 4'b0100;
    #1;
    check("rstb_b1_idx", 64'(oup_idx_o), 2);
    tick;
    check("rstb_b2_locked", 64'(locked_o), 1);
    rst_i = 1'b0;
    #1;
    check("rstb_async_locked", 64'(locked_o), 0);
    tick;
    rst_i = 1'b1;
    set_m(2, 0, 0);
    inp_valid_i = 4'b0110;
    #1;
    check("rstb_fresh_idx", 64'(oup_idx_o), 1);
    check("rstb_fresh_locked", 64'(locked_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
